// File: rtl/coin_pkg.sv
// Shared state encoding and default sizing constants for the coin board.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CLEAR
    } state_t;

    localparam int DEF_ROWS        = 12;
    localparam int DEF_COLS        = 12;
    localparam int DEF_CELL_BITS   = 5;
    localparam int DEF_SCORE_W     = 16;
    localparam int DEF_COIN_PTS    = 10;
    localparam int DEF_POWER_PTS   = 50;
    localparam int DEF_POWER_TICKS = 600;

endpackage

// File: rtl/coin_board_power_timer.sv
// Power-mode countdown: reloads on a power-coin eat, counts frame ticks down to zero.
module power_timer
    import coin_pkg::*;
#(
    parameter int TICKS = DEF_POWER_TICKS,
    parameter int W     = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         cancel,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         active
);

    logic [W-1:0] count_next;

    // A fresh board cancels power mode outright; a re-eat restarts the full duration.
    always_comb begin
        count_next = count;
        if (cancel) begin
            count_next = '0;
        end else if (load) begin
            count_next = W'(TICKS);
        end else if (tick && count != '0) begin
            count_next = count - W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count  <= '0;
            active <= 1'b0;
        end else begin
            count  <= count_next;
            active <= (count_next != '0);
        end
    end

endmodule

// File: rtl/coin_board.sv
// Coin grid under a moving player: eats coins at cell crossroads, keeps a saturating
// score, tracks remaining coins and drives a power-mode timer for power coins.
module coin_board
    import coin_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int CELL_BITS   = DEF_CELL_BITS,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int COIN_PTS    = DEF_COIN_PTS,
    parameter int POWER_PTS   = DEF_POWER_PTS,
    parameter int POWER_TICKS = DEF_POWER_TICKS
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   load,
    input  logic                   scoreClear,
    input  logic [ROWS*COLS-1:0]   coinArrangement,
    input  logic [ROWS*COLS-1:0]   powerArrangement,
    input  logic [9:0]             playerPosX,
    input  logic [9:0]             playerPosY,
    input  logic                   frameTick,
    output logic [ROWS*COLS-1:0]   presentCheck,
    output logic [9:0]             coinsLeft,
    output logic [SCORE_W-1:0]     score,
    output logic                   eatPulse,
    output logic                   powerActive,
    output logic                   boardCheck
);

    localparam int N       = ROWS * COLS;
    localparam int TIMER_W = (POWER_TICKS > 0) ? $clog2(POWER_TICKS + 1) : 1;

    localparam logic [N-1:0]     ONE       = N'(1);
    localparam logic [9:0]       LOW_MASK  = 10'((1 << CELL_BITS) - 1);
    localparam logic [SCORE_W:0] COIN_ADD  = (SCORE_W + 1)'(COIN_PTS);
    localparam logic [SCORE_W:0] POWER_ADD = (SCORE_W + 1)'(POWER_PTS);

    state_t               state;
    logic [N-1:0]         power_map;
    logic [9:0]           cell_row;
    logic [9:0]           cell_col;
    logic                 crossroad;
    logic                 in_range;
    logic [N-1:0]         cell_mask;
    logic                 hit;
    logic                 hit_power;
    logic                 eat;
    logic [9:0]           load_count;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_eat;
    logic [TIMER_W-1:0]   power_ticks_unused;

    function automatic logic [9:0] popcount(input logic [N-1:0] v);
        logic [9:0] n;
        n = '0;
        for (int i = 0; i < N; i++) begin
            n = n + 10'(v[i]);
        end
        return n;
    endfunction

    // Locate the player's cell; only an exact cell corner inside the grid can select a coin.
    always_comb begin
        cell_row  = playerPosY >> CELL_BITS;
        cell_col  = playerPosX >> CELL_BITS;
        crossroad = ((playerPosX & LOW_MASK) == '0) && ((playerPosY & LOW_MASK) == '0);
        in_range  = (cell_row >= 10'd1) && (cell_row <= 10'(ROWS)) &&
                    (cell_col >= 10'd1) && (cell_col <= 10'(COLS));
        cell_mask = '0;
        if (in_range) begin
            cell_mask = ONE << ((ROWS - int'(cell_row)) * COLS + (COLS - int'(cell_col)));
        end
        hit        = |(presentCheck & cell_mask);
        hit_power  = |(power_map & cell_mask);
        eat        = (state == PLAY) && crossroad && hit && !load;
        load_count = popcount(coinArrangement);
        score_sum  = {1'b0, score} + (hit_power ? POWER_ADD : COIN_ADD);
        score_eat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    // A load always beats a same-cycle eat; the score is independent of loads.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= IDLE;
            presentCheck <= '0;
            power_map    <= '0;
            coinsLeft    <= '0;
            score        <= '0;
            eatPulse     <= 1'b0;
            boardCheck   <= 1'b0;
        end else begin
            eatPulse <= eat;
            if (scoreClear) begin
                score <= '0;
            end else if (eat) begin
                score <= score_eat;
            end
            if (load) begin
                presentCheck <= coinArrangement;
                power_map    <= powerArrangement & coinArrangement;
                coinsLeft    <= load_count;
                state        <= (load_count != '0) ? PLAY : CLEAR;
                boardCheck   <= (load_count == '0);
            end else if (eat) begin
                presentCheck <= presentCheck & ~cell_mask;
                coinsLeft    <= coinsLeft - 10'd1;
                if (coinsLeft == 10'd1) begin
                    state      <= CLEAR;
                    boardCheck <= 1'b1;
                end
            end
        end
    end

    power_timer #(
        .TICKS (POWER_TICKS),
        .W     (TIMER_W)
    ) u_power_timer (
        .Clk    (Clk),
        .Reset  (Reset),
        .load   (eat && hit_power),
        .cancel (load),
        .tick   (frameTick),
        .count  (power_ticks_unused),
        .active (powerActive)
    );

endmodule

// File: doc/coin_board.md
COIN_BOARD -- requirements
Module: coin_board

Interface
REQ-001 The block SHALL have parameter ROWS, default 12, number of board rows (1..31).
REQ-002 The block SHALL have parameter COLS, default 12, number of board columns (1..31).
REQ-003 The block SHALL have parameter CELL_BITS, default 5, log2 of the cell size in pixels.
REQ-004 The block SHALL have parameter SCORE_W, default 16, score width.
REQ-005 The block SHALL have parameters COIN_PTS (default 10) and POWER_PTS (default 50): points per coin and per power coin.
REQ-006 The block SHALL have parameter POWER_TICKS, default 600, power-mode duration in frameTick pulses.
REQ-007 The block SHALL have port Clk, input, 1, the single clock.
REQ-008 The block SHALL have port Reset, input, 1, reset, synchronous and active-low.
REQ-009 The block SHALL have port load, input, 1, one-cycle level-load strobe.
REQ-010 The block SHALL have port scoreClear, input, 1, zero the score.
REQ-011 The block SHALL have port coinArrangement, input, ROWS*COLS, coin map.
REQ-012 The block SHALL have port powerArrangement, input, ROWS*COLS, power-coin map.
REQ-013 The block SHALL have ports playerPosX and playerPosY, input, 10 each, pixel position.
REQ-014 The block SHALL have port frameTick, input, 1, one pulse per frame.
REQ-015 The block SHALL have port presentCheck, output, ROWS*COLS, live coin map.
REQ-016 The block SHALL have port coinsLeft, output, 10, remaining coin count.
REQ-017 The block SHALL have port score, output, SCORE_W, accumulated points.
REQ-018 The block SHALL have port eatPulse, output, 1, one-cycle strobe per coin eaten.
REQ-019 The block SHALL have port powerActive, output, 1, power mode running.
REQ-020 The block SHALL have port boardCheck, output, 1, board cleared.

Function
REQ-021 Cell (r,c), both 1-based, SHALL map to bit (ROWS-r)*COLS+(COLS-c), so (1,1) is the MSB.
REQ-022 Player cell SHALL be (playerPosY>>CELL_BITS, playerPosX>>CELL_BITS).
REQ-023 crossroad SHALL be true when the low CELL_BITS bits of both positions are zero.
REQ-024 The FSM SHALL have states IDLE, PLAY and CLEAR.
REQ-025 load in any state SHALL, next cycle, set presentCheck=coinArrangement, store powerArrangement&coinArrangement, set coinsLeft=popcount(coinArrangement) and cancel power mode.
REQ-026 After a load, the FSM SHALL enter PLAY if the count is nonzero, else CLEAR.
REQ-027 In PLAY, if crossroad, the player cell is in range (1..ROWS, 1..COLS) and its bit is set, the block SHALL on the next edge clear the bit, pulse eatPulse and decrement coinsLeft.
REQ-028 That same eat SHALL add POWER_PTS to score if the power bit is set, else COIN_PTS.
REQ-029 A cell SHALL be eaten at most once per load; standing on it afterwards has no effect.
REQ-030 Out-of-range cells and the row/column 0 border SHALL never eat.
REQ-031 Score SHALL saturate at 2^SCORE_W-1 and SHALL persist across load.
REQ-032 scoreClear SHALL zero score; if scoreClear and an eat coincide, the result SHALL be 0.
REQ-033 An eat that drives coinsLeft to 0 SHALL move the FSM to CLEAR in the same edge; boardCheck=1 in CLEAR only.
REQ-034 Eating a power coin SHALL load the power timer with POWER_TICKS; powerActive=1 while the timer is nonzero.
REQ-035 The timer SHALL decrement on each frameTick; a re-eat reloads it without stacking.
REQ-036 The power timer SHALL keep running in CLEAR until it expires or load occurs.
REQ-037 load and an eat in the same cycle: load SHALL win; the eat is discarded and gives no score or pulse.
REQ-038 In IDLE and CLEAR, no eat SHALL occur.
REQ-039 Output latency SHALL be 1 cycle from the qualifying inputs; all outputs are registered.

Reset
REQ-040 While Reset=0 at a Clk edge, the block SHALL set: state IDLE, presentCheck 0, power map 0, coinsLeft 0, score 0, eatPulse 0, timer 0, powerActive 0, boardCheck 0.
REQ-041 Reset SHALL dominate load and scoreClear.
REQ-042 Reset asserted mid-play SHALL discard all board and score state.

Structure
REQ-043 Package coin_pkg SHALL hold the state enum and the default parameter constants.
REQ-044 The block SHALL contain one sub-module, power_timer (load, tick, count, active).

Verification
REQ-045 Reset, then load a map with (1,1) and (12,12) set -> presentCheck bits 143 and 0 set, coinsLeft=2, state PLAY.
REQ-046 Player at (32,32) (cell (1,1)) -> next cycle bit 143=0, eatPulse one cycle, score=10, coinsLeft=1; holding there yields no further eat.
REQ-047 (12,12) marked power, player at (384,384) -> score=60, boardCheck=1, powerActive=1 for 600 frameTicks, then 0.
REQ-048 Player at (33,32) -> no eat; at (0,0) -> no eat.
REQ-049 load coincident with a qualifying eat -> board reloaded, no eatPulse, score unchanged.
REQ-050 Score preset near max by repeated loads and eats -> saturates at 65535; scoreClear -> 0.
